aes_round_pipe: RTL and testbench

- Parametrised, fully pipelined single AES round for the 128-bit datapath.
- One build-time parameter selects forward cipher or inverse cipher order; a second enables or bypasses the (Inv)MixColumns stage for the final round.
- Has full AXI-Stream backpressure, carries the round key and tlast alongside each block, and sustains one block per clock.
- Instantiated per round by the key-expansion and round-chaining wrappers.

---
 rtl/aes_round_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_aes_round_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_pipe.sv
// Single AES round (forward or inverse) as a four-stage AXI-Stream pipeline.
// The round key and tlast are captured with each accepted block and travel with it.
package aes_round_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{b[i]}});
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
        return o;
    endfunction

    // coef holds the first matrix row, element j in bits [8j+:8]; later rows are rotations.
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] o;
        logic [7:0]   acc;
        o = 128'd0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(coef[8*((j-r+4)%4) +: 8], s[8*(4*c+j) +: 8]);
                o[8*(4*c+r) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return mix_cols(s, 32'h01010302);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return mix_cols(s, 32'h090d0b0e);
    endfunction

endpackage

module aes_round_pipe
    import aes_round_pkg::*;
#(
    parameter bit DECRYPT        = 1'b0,
    parameter bit MIX_COLUMNS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] aes_in_tdata,
    input  logic         aes_in_tvalid,
    input  logic         aes_in_tlast,
    output logic         aes_in_tready,
    input  logic [127:0] round_key,
    output logic [127:0] aes_out_tdata,
    output logic         aes_out_tvalid,
    output logic         aes_out_tlast,
    input  logic         aes_out_tready
);

    localparam int NSTG = 4;

    logic         r_vld   [1:NSTG];
    logic [127:0] r_state [1:NSTG];
    logic         r_last  [1:NSTG];
    // The key is consumed by stage 3 (inverse) or stage 4 (forward), so S4 never needs a copy.
    logic [127:0] r_key   [1:NSTG-1];

    logic         w_rdy1, w_rdy2, w_rdy3, w_rdy4;
    logic         w_rdy     [1:NSTG];
    logic         w_ld      [1:NSTG];
    logic         w_up_vld  [1:NSTG];
    logic         w_up_last [1:NSTG];
    logic [127:0] w_fn      [1:NSTG];

    assign w_rdy4 = !r_vld[4] || aes_out_tready;
    assign w_rdy3 = !r_vld[3] || w_rdy4;
    assign w_rdy2 = !r_vld[2] || w_rdy3;
    assign w_rdy1 = !r_vld[1] || w_rdy2;

    // Per-stage upstream view and load strobes.
    always_comb begin
        w_rdy[1]     = w_rdy1;
        w_rdy[2]     = w_rdy2;
        w_rdy[3]     = w_rdy3;
        w_rdy[4]     = w_rdy4;
        w_up_vld[1]  = aes_in_tvalid;
        w_up_last[1] = aes_in_tlast;
        for (int k = 2; k <= NSTG; k++) begin
            w_up_vld[k]  = r_vld[k-1];
            w_up_last[k] = r_last[k-1];
        end
        for (int k = 1; k <= NSTG; k++) w_ld[k] = w_up_vld[k] && w_rdy[k];
    end

    // Stage transforms, each computed from the block about to enter that stage.
    always_comb begin
        if (DECRYPT) begin
            w_fn[1] = inv_shift_rows(aes_in_tdata);
            w_fn[2] = inv_sub_bytes(r_state[1]);
            w_fn[3] = r_state[2] ^ r_key[2];
            w_fn[4] = MIX_COLUMNS_EN ? inv_mix_columns(r_state[3]) : r_state[3];
        end else begin
            w_fn[1] = sub_bytes(aes_in_tdata);
            w_fn[2] = shift_rows(r_state[1]);
            w_fn[3] = MIX_COLUMNS_EN ? mix_columns(r_state[2]) : r_state[2];
            w_fn[4] = r_state[3] ^ r_key[3];
        end
    end

    // Stage registers: a ready stage takes the upstream valid bit and, if set, the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= NSTG; k++) begin
                r_vld[k]   <= 1'b0;
                r_state[k] <= 128'd0;
                r_last[k]  <= 1'b0;
            end
            for (int k = 1; k <= NSTG-1; k++) r_key[k] <= 128'd0;
        end else begin
            for (int k = 1; k <= NSTG; k++) begin
                if (w_rdy[k]) r_vld[k] <= w_up_vld[k];
                if (w_ld[k]) begin
                    r_state[k] <= w_fn[k];
                    r_last[k]  <= w_up_last[k];
                end
            end
            if (w_ld[1]) r_key[1] <= round_key;
            if (w_ld[2]) r_key[2] <= r_key[1];
            if (w_ld[3]) r_key[3] <= r_key[2];
        end
    end

    assign aes_in_tready  = w_rdy1;
    assign aes_out_tdata  = r_state[4];
    assign aes_out_tvalid = r_vld[4];
    assign aes_out_tlast  = r_last[4];

endmodule

// File: tb/tb_aes_round_pipe.sv
// Bench for aes_round_pipe: four parameter variants driven in lockstep, checked by a
// scoreboard against a table-based (log/antilog GF arithmetic) AES round model.
module tb_aes_round_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] in_data, in_key;
    logic         in_valid, in_last, out_ready;
    logic [127:0] o_data  [4];
    logic         o_valid [4];
    logic         o_last  [4];
    logic         o_inrdy [4];

    // Instance g: DECRYPT = (g >= 2), MIX_COLUMNS_EN = (g even).
    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_round_pipe #(.DECRYPT(g >= 2), .MIX_COLUMNS_EN((g % 2) == 0)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .aes_in_tdata   (in_data),
            .aes_in_tvalid  (in_valid),
            .aes_in_tlast   (in_last),
            .aes_in_tready  (o_inrdy[g]),
            .round_key      (in_key),
            .aes_out_tdata  (o_data[g]),
            .aes_out_tvalid (o_valid[g]),
            .aes_out_tlast  (o_last[g]),
            .aes_out_tready (out_ready)
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int n_lastout = 0;

    typedef struct packed {
        logic [3:0][127:0] d;
        logic              l;
    } exp_t;
    exp_t exp_q[$];

    int         gexp [256];
    int         glog [256];
    logic [7:0] sb   [256];
    logic [7:0] isb  [256];
    logic [7:0] fwd_m [4][4];
    logic [7:0] inv_m [4][4];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return gexp[(glog[a] + glog[b]) % 255][7:0];
    endfunction

    task automatic build_tables();
        int x;
        logic [7:0] y, b, cst;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x ^ (((x << 1) ^ (((x & 128) != 0) ? 27 : 0)) & 255);
        end
        gexp[255] = 1;
        cst = 8'h63;
        for (int v = 0; v < 256; v++) begin
            y = (v == 0) ? 8'd0 : gexp[(255 - glog[v]) % 255][7:0];
            for (int i = 0; i < 8; i++)
                b[i] = y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8] ^ cst[i];
            sb[v] = b;
            isb[b] = v[7:0];
        end
        fwd_m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                  '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        inv_m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                  '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    endtask

    // Reference AES round on a 4x4 byte matrix a[row][col].
    function automatic logic [127:0] ref_round(input bit dec, input bit mix,
                                               input logic [127:0] d, input logic [127:0] k);
        logic [7:0] a [4][4];
        logic [7:0] b [4][4];
        logic [7:0] kk [4][4];
        logic [7:0] acc;
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a[r][c]  = d[8*(4*c+r) +: 8];
                kk[r][c] = k[8*(4*c+r) +: 8];
            end
        if (!dec) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b[r][c] = sb[a[r][c]];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a[r][c] = b[r][(c+r)%4];
        end else begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b[r][c] = a[r][(c-r+4)%4];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a[r][c] = isb[b[r][c]] ^ kk[r][c];
        end
        if (mix) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    acc = 8'd0;
                    for (int j = 0; j < 4; j++)
                        acc = acc ^ gmul(dec ? inv_m[r][j] : fwd_m[r][j], a[j][c]);
                    b[r][c] = acc;
                end
            a = b;
        end
        if (!dec)
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a[r][c] = a[r][c] ^ kk[r][c];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[8*(4*c+r) +: 8] = a[r][c];
        return o;
    endfunction

    // Written with the first byte leftmost; returns it with that byte at tdata[7:0].
    function automatic logic [127:0] le(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: records accepted beats into the scoreboard, checks delivered beats and stalls.
    logic         hold_v [4];
    logic [127:0] hold_d [4];
    logic         hold_l [4];
    exp_t         e_push, e_pop;
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hold_v[i] = 1'b0;
        end else begin
            for (int i = 1; i < 4; i++) chk($sformatf("in_tready_lockstep[%0d]", i), o_inrdy[i], o_inrdy[0]);
            for (int i = 0; i < 4; i++) begin
                if (hold_v[i]) begin
                    chk($sformatf("stall_valid[%0d]", i), o_valid[i], 1);
                    chk($sformatf("stall_data[%0d]", i), o_data[i], hold_d[i]);
                    chk($sformatf("stall_last[%0d]", i), o_last[i], hold_l[i]);
                end
                hold_v[i] = o_valid[i] && !out_ready;
                hold_d[i] = o_data[i];
                hold_l[i] = o_last[i];
            end
            if (in_valid && o_inrdy[0]) begin
                for (int i = 0; i < 4; i++) e_push.d[i] = ref_round(i >= 2, (i % 2) == 0, in_data, in_key);
                e_push.l = in_last;
                exp_q.push_back(e_push);
                n_acc++;
            end
            if (o_valid[0] && out_ready) begin
                n_out++;
                if (o_last[0]) n_lastout++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_beat_unexpected got=%h exp=<none>", o_data[0]);
                end else begin
                    e_pop = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("out_valid[%0d]", i), o_valid[i], 1);
                        chk($sformatf("out_data[%0d]", i), o_data[i], e_pop.d[i]);
                        chk($sformatf("out_last[%0d]", i), o_last[i], e_pop.l);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_last  = l;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_inrdy[0];
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accepted", acc, 1);
    endtask

    task automatic kat(input string name, input int idx, input logic [127:0] d,
                       input logic [127:0] k, input logic [127:0] exp);
        out_ready = 1'b1;
        send(d, k, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_not_yet_valid"}, o_valid[idx], 0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, o_valid[idx], 1);
        chk({name, "_data"}, o_data[idx], exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_acc, base_out, base_last, sent, cyc, n;
        bit acc;
        build_tables();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 128'd0;
        in_key    = 128'd0;
        out_ready = 1'b0;
        #12;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_valid[%0d]", i), o_valid[i], 0);
            chk($sformatf("rst_data[%0d]", i), o_data[i], 0);
            chk($sformatf("rst_last[%0d]", i), o_last[i], 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_tready", o_inrdy[0], 1);

        // Known answers
        kat("kat_fwd_zero", 0, 128'd0, 128'd0, {16{8'h63}});
        kat("kat_fips_r1", 0, le(128'h193de3bea0f4e22b9ac68d2ae9f84808),
            le(128'ha0fafe1788542cb123a339392a6c7605), le(128'ha49c7ff2689f352b6b5bea43026a5049));
        kat("kat_inv_nomix_ff", 3, {16{8'h63}}, {128{1'b1}}, {128{1'b1}});
        kat("kat_inv_nomix_0", 3, {16{8'h63}}, 128'd0, 128'd0);
        kat("kat_inv_mix_0", 2, {16{8'h63}}, 128'd0, 128'd0);

        // Backpressure: 8-block packet against a 10-cycle output stall
        base_acc  = n_acc;
        base_out  = n_out;
        base_last = n_lastout;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd128(), rnd128(), i == 7);
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("bp_accepted_while_stalled", n_acc - base_acc, 4);
                chk("bp_in_tready_full", o_inrdy[0], 0);
                chk("bp_out_valid_full", o_valid[0], 1);
                out_ready = 1'b1;
            end
        join
        n = 0;
        while ((n_out - base_out) < 8 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_count", n_out - base_out, 8);
        chk("bp_last_count", n_lastout - base_last, 1);

        // Random traffic, random downstream ready, key changing every cycle
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid && ($urandom % 4) != 0) begin
                in_valid = 1'b1;
                in_data  = rnd128();
                in_last  = 1'($urandom % 2);
            end
            in_key    = rnd128();
            out_ready = 1'($urandom % 2);
            @(negedge clk);
            acc = in_valid && o_inrdy[0];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rand_sent", sent, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rand_drained", exp_q.size(), 0);

        // Reset mid-stream with three blocks stalled inside
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd128(), rnd128(), 1'b1);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_out_valid", o_valid[0], 1);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst_valid[%0d]", i), o_valid[i], 0);
            chk($sformatf("async_rst_data[%0d]", i), o_data[i], 0);
            chk($sformatf("async_rst_last[%0d]", i), o_last[i], 0);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_rst_in_tready", o_inrdy[0], 1);
        base_out = n_out;
        kat("post_rst_block", 0, 128'd0, 128'd0, {16{8'h63}});
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_count", n_out - base_out, 1);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
